// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit responder: register offsets, bit positions, FSM states.
// UART_TX_PARITY_EN adds the PARITY state to the state enum.
package uart_tx_pkg;

    localparam logic [7:0] ADDR_TXDATA = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_CTRL   = 8'h08;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_EMPTY_BIT = 2;
    localparam int STATUS_OVF_BIT   = 3;

    localparam int CTRL_EN_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate counter.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    // Storage is data only; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_responder.sv
// Memory-mapped UART transmitter: TXDATA pushes into a byte FIFO, an FSM serialises 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_responder
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wd,
    input  logic [7:0]  address,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rd,
    output logic        tx
);

    localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

    tx_state_e   state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        overflow;
    logic        enable;
    logic        busy;
    logic        wr_txdata;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;
    logic        unused_wd;

    assign unused_wd = ^wd[31:8];
    assign busy      = (state != ST_IDLE);
    assign wr_txdata = we && (address == ADDR_TXDATA);
    assign fifo_push = wr_txdata && !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty && enable;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .pop  (fifo_pop),
        .wdata(wd[7:0]),
        .rdata(fifo_head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            enable   <= 1'b1;
        end else begin
            if (wr_txdata && fifo_full)
                overflow <= 1'b1;
            else if (we && (address == ADDR_STATUS) && wd[STATUS_OVF_BIT])
                overflow <= 1'b0;
            if (we && (address == ADDR_CTRL))
                enable <= wd[CTRL_EN_BIT];
        end
    end

    always_comb begin
        rd = '0;
        if (re) begin
            case (address)
                ADDR_STATUS: begin
                    rd[STATUS_BUSY_BIT]  = busy;
                    rd[STATUS_FULL_BIT]  = fifo_full;
                    rd[STATUS_EMPTY_BIT] = fifo_empty;
                    rd[STATUS_OVF_BIT]   = overflow;
                end
                ADDR_CTRL: rd[CTRL_EN_BIT] = enable;
                default:   rd = '0;
            endcase
        end
    end

    // tx is registered and updated on the same edge as the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (fifo_pop) begin
                        state   <= ST_START;
                        tx      <= 1'b0;
                        bit_cnt <= BIT_RELOAD;
                        shreg   <= fifo_head;
                    end
                end
                ST_START: begin
                    if (bit_cnt == 16'd0) begin
                        state   <= ST_DATA;
                        tx      <= shreg[0];
                        bit_idx <= 3'd0;
                        bit_cnt <= BIT_RELOAD;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == 16'd0) begin
                        bit_cnt <= BIT_RELOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            tx    <= ^shreg;
`else
                            state <= ST_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_cnt == 16'd0) begin
                        state   <= ST_STOP;
                        tx      <= 1'b1;
                        bit_cnt <= BIT_RELOAD;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    tx <= 1'b1;
                    if (bit_cnt == 16'd0)
                        state <= ST_IDLE;
                    else
                        bit_cnt <= bit_cnt - 16'd1;
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_responder.sv
// Self-checking bench for uart_tx_responder with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_responder;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYCLES = FRAME_BITS * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wd;
    logic [7:0]  address;
    logic        we;
    logic        re;
    logic [31:0] rd;
    logic        tx;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_responder #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wd     (wd),
        .address(address),
        .we     (we),
        .re     (re),
        .rd     (rd),
        .tx     (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_tx;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        we = 1'b1; address = a; wd = d;
        step();
        we = 1'b0; wd = '0;
    endtask

    task automatic read_status(output logic [31:0] v);
        re = 1'b1; address = 8'h04;
        #1;
        v  = rd;
        re = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        re = 1'b1; address = 8'h04;
        #1;
        while (rd[0] !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        check(name, {31'b0, rd[0]}, 32'h0);
    endtask

    function automatic logic exp_tx(input logic [7:0] b, input int k);
        int slot = (k - 1) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (FRAME_BITS == 11 && slot == 9) return ^b;
        return 1'b1;
    endfunction

    // Called right after the TXDATA write edge with an empty FIFO and an idle line.
    task automatic frame_check(input logic [7:0] b);
        re = 1'b1; address = 8'h04;
        #1;
        check("pre_start_tx", {31'b0, tx}, 32'h1);
        for (int k = 1; k <= FRAME_CYCLES; k++) begin
            step();
            check($sformatf("frame_%02h_cycle%0d_tx_busy", b, k),
                  {30'b0, tx, rd[0]}, {30'b0, exp_tx(b, k), 1'b1});
        end
        step();
        check("frame_end_tx_busy", {30'b0, tx, rd[0]}, {30'b0, 1'b1, 1'b0});
        re = 1'b0;
    endtask

    task automatic recv_frame(output logic [7:0] b, output logic par, output int waited);
        waited = 0;
        b      = '0;
        par    = 1'b0;
        while (tx !== 1'b0 && waited < 200) begin
            step();
            waited++;
        end
        check("recv_start", {31'b0, tx}, 32'h0);
        repeat (CPB / 2) step();
        check("recv_start_mid", {31'b0, tx}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) step();
            b[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) step();
        par = tx;
`endif
        repeat (CPB) step();
        check("recv_stop", {31'b0, tx}, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] st;
        logic [7:0]  b;
        logic        p;
        int          w;
        logic        any_low;

        rst = 1'b1; we = 1'b0; re = 1'b0; address = '0; wd = '0;
        repeat (3) step();
        check("reset_tx", {31'b0, tx}, 32'h1);
        rst = 1'b0;

        // Register access table, starting from the reset state.
        vecs[0]  = '{1'b0, 1'b1, 8'h04, 32'h0, 32'h4, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 8'h08, 32'h0, 32'h1, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 8'h0C, 32'h0, 32'h0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 8'h04, 32'h0, 32'h0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 8'h00, 32'h0, 32'h0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 8'h08, 32'h0, 32'h0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 8'h08, 32'h0, 32'h0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 8'h08, 32'h1, 32'h0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 8'h08, 32'h0, 32'h1, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 8'h10, 32'hFF, 32'h0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 8'h04, 32'h0, 32'h4, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 8'h04, 32'h8, 32'h4, 1'b1};
        for (int i = 0; i < 12; i++) begin
            we = vecs[i].we; re = vecs[i].re; address = vecs[i].addr; wd = vecs[i].wd;
            #1;
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_tx", i), {31'b0, tx}, {31'b0, vecs[i].exp_tx});
            step();
        end
        we = 1'b0; re = 1'b0; wd = '0;
        step();

        // Single 0x55 frame, cycle by cycle.
        bus_write(8'h00, 32'h55);
        frame_check(8'h55);

        // Six back-to-back writes: one pops, four queue, the sixth overflows.
        for (int i = 0; i < 6; i++) begin
            we = 1'b1; address = 8'h00; wd = 32'h10 + i;
            step();
        end
        we = 1'b0; wd = '0;
        read_status(st);
        check("status_overflow", st, 32'hB);
        bus_write(8'h04, 32'h8);
        read_status(st);
        check("status_ovf_cleared", st, 32'h3);
        wait_idle("frame1_done");
        check("idle_gap_status", rd, 32'h2);
        re = 1'b0;
        for (int j = 0; j < 4; j++) begin
            recv_frame(b, p, w);
            check($sformatf("queued_byte%0d", j), {24'b0, b}, 32'h11 + j);
            check($sformatf("queued_gap%0d", j), w, (j == 0) ? 1 : 3);
        end
        wait_idle("queue_drained");
        re = 1'b0;
        read_status(st);
        check("dropped_byte_not_sent", st, 32'h4);

        // Disabled pops: byte waits until enable returns.
        bus_write(8'h08, 32'h0);
        bus_write(8'h00, 32'hA3);
        any_low = 1'b0;
        repeat (8) begin
            step();
            if (tx !== 1'b1) any_low = 1'b1;
        end
        check("disabled_tx_idle", {31'b0, any_low}, 32'h0);
        read_status(st);
        check("disabled_status", st, 32'h0);
        bus_write(8'h08, 32'h1);
        check("enable_edge_tx", {31'b0, tx}, 32'h1);
        step();
        check("enable_next_edge_tx", {31'b0, tx}, 32'h0);
        recv_frame(b, p, w);
        check("enabled_byte", {24'b0, b}, 32'hA3);
        check("enabled_wait", w, 0);
`ifdef UART_TX_PARITY_EN
        check("enabled_parity", {31'b0, p}, 32'h0);
`endif
        wait_idle("enabled_done");
        re = 1'b0;

        // Reset at cycle 10 of a 0xFF frame with a second byte queued.
        bus_write(8'h00, 32'hFF);
        we = 1'b1; address = 8'h00; wd = 32'h81;
        step();
        we = 1'b0; wd = '0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_frame_tx", {31'b0, tx}, 32'h1);
        read_status(st);
        check("rst_mid_frame_status", st, 32'h4);
        any_low = 1'b0;
        repeat (50) begin
            step();
            if (tx !== 1'b1) any_low = 1'b1;
        end
        check("rst_queue_discarded", {31'b0, any_low}, 32'h0);

        // Reset during a start bit, with enable cleared in flight.
        bus_write(8'h00, 32'h00);
        step();
        bus_write(8'h08, 32'h0);
        check("inflight_after_disable_tx", {31'b0, tx}, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_start_bit_tx", {31'b0, tx}, 32'h1);
        re = 1'b1; address = 8'h08;
        #1;
        check("rst_enable_restored", rd, 32'h1);
        re = 1'b0;
        #1;
        check("rd_zero_without_re", rd, 32'h0);
        step();

`ifdef UART_TX_PARITY_EN
        bus_write(8'h00, 32'h07);
        frame_check(8'h07);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_responder.md
UART_TX_RESPONDER -- requirements
Module: uart_tx_responder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning TX byte FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port wd, input, 32, bus write data from the memory map.
REQ-006 SHALL have port address, input, 8, byte offset within the block.
REQ-007 SHALL have port we, input, 1, bus write strobe, one transfer per cycle high.
REQ-008 SHALL have port re, input, 1, bus read strobe.
REQ-009 SHALL have port rd, output, 32, bus read data.
REQ-010 SHALL have port tx, output, 1, serial line, idle high.

Function
REQ-011 Register map SHALL be: 0x00 TXDATA (write only), 0x04 STATUS (read/write), 0x08 CTRL (read/write); other offsets read 0 and ignore writes.
REQ-012 A write to TXDATA SHALL push wd[7:0] into the FIFO when the FIFO is not full at that edge.
REQ-013 A write to TXDATA while full SHALL drop the byte and set STATUS.overflow (bit3), which is sticky.
REQ-014 STATUS SHALL read {28'b0, overflow, empty, full, busy} in bits [3:0]; busy is high whenever the FSM is not IDLE.
REQ-015 A write to STATUS with wd[3]=1 SHALL clear overflow; other bits read-only.
REQ-016 CTRL bit0 (enable, reset 1) SHALL gate FIFO pops; when 0, queued bytes wait and an in-flight frame completes.
REQ-017 rd SHALL be combinational from address while re=1 and SHALL be 0 while re=0.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY (only with REQ-028), STOP.
REQ-019 IDLE->START SHALL occur on the edge where FIFO is non-empty and enable=1, popping the head byte into a shift register.
REQ-020 Each of START, each DATA bit, PARITY and STOP SHALL hold tx for exactly CLKS_PER_BIT cycles via a down-counter reloaded to CLKS_PER_BIT-1.
REQ-021 tx SHALL be 0 in START, shift-register LSB-first in DATA (8 bits, 3-bit index), 1 in STOP and IDLE.
REQ-022 STOP SHALL return to IDLE; back-to-back frames SHALL insert exactly one IDLE cycle.
REQ-023 tx SHALL fall on the edge one cycle after the TXDATA write edge when FIFO was empty and FSM idle.
REQ-024 Simultaneous push and pop SHALL both take effect; a push to a full FIFO in the same edge as a pop SHALL be dropped (full evaluated before the edge).
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH with an extra bit distinguishing full from empty.

Reset
REQ-026 On rst: tx=1, FSM IDLE, FIFO empty, overflow=0, enable=1, counter and shift register 0; rd follows REQ-017.
REQ-027 rst mid-frame SHALL abort the frame and discard queued bytes; tx=1 after that edge.

Configuration
REQ-028 With UART_TX_PARITY_EN defined, PARITY SHALL follow DATA and drive even parity (XOR of the 8 data bits); frame = 11 bits. Without the macro, PARITY and its logic SHALL not exist; frame = 10 bits.

Structure
REQ-029 A shared package uart_tx_pkg SHALL hold register offsets, STATUS/CTRL bit positions and the FSM state enum.
REQ-030 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; push, pop, full, empty).

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Write 0x55 to 0x00 -> tx low one cycle later, then 1,0,1,0,1,0,1,0, then stop 1, each 4 cycles; busy high 40 cycles.
REQ-032 Six back-to-back writes with no gap -> first pops immediately, next four queue, sixth dropped; STATUS reads 0xB (overflow, full, busy); writing 0x8 to 0x04 clears bit3.
REQ-033 Write CTRL=0, then push 0xA3 -> tx stays 1, STATUS empty=0; write CTRL=1 -> frame starts next edge.
REQ-034 Assert rst at cycle 10 of a 0xFF frame -> tx=1 on the next edge, STATUS reads 0x4.
REQ-035 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1 between bit7 and stop; frame 44 cycles.
REQ-036 Read 0x0C with re=1 -> rd=0; any read with re=0 -> rd=0.
